// File: rtl/rx_collector_pkg.sv
// Shared state encoding and default sizing for the RX return-line collector.
// Used by rx_collector and rx_sync; optional collision counting is RX_COLLECTOR_COLLISION_CNT_EN.
package rx_collector_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int COLL_CNT_W      = 8;
  localparam int DEF_NCH         = 22;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_IDLE_CYCLES = 1250;

endpackage

// File: rtl/rx_sync.sv
// One-bit synchronizer whose flops reset to 1, so an idle-high line never shows a false start bit.
// Latency SYNC_STAGES clock edges; no flow control.
module rx_sync
  import rx_collector_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic core_clk_i,
  input  logic arst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge core_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_collector.sv
// Merges NCH idle-high UART return lines onto one host RX line by locking the first channel to go low.
// Latency SYNC_STAGES+1 edges IN->OUT; no backpressure. Collision counter built only with RX_COLLECTOR_COLLISION_CNT_EN.
module rx_collector
  import rx_collector_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int SEL_W       = $clog2(NCH)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NCH-1:0]        IN,
  output logic                  OUT,
  output logic                  LED,
  output logic                  BUSY,
  output logic [SEL_W-1:0]      SEL,
  output logic [COLL_CNT_W-1:0] COLL_CNT
);

  localparam int              CNT_W    = $clog2(IDLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

  logic [NCH-1:0]   s;
  logic             any_low;
  logic [SEL_W-1:0] low_idx;

  state_e           state_q, state_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_sync
    rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .core_clk_i(CLK),
      .arst_n_i  (RST_N),
      .d_i       (IN[gi]),
      .q_o       (s[gi])
    );
  end

  // Lowest index wins when several lines drop in the same cycle.
  always_comb begin
    any_low = 1'b0;
    low_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!s[i] && !any_low) begin
        any_low = 1'b1;
        low_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    busy_d  = busy_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        out_d = 1'b1;
        if (any_low) begin
          state_d = ST_LOCKED;
          sel_d   = low_idx;
          busy_d  = 1'b1;
          out_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        out_d = s[sel_q];
        // A low on the terminal-count cycle keeps the lock.
        if (!s[sel_q]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign OUT  = out_q;
  assign LED  = ~out_q;
  assign BUSY = busy_q;
  assign SEL  = sel_q;

`ifdef RX_COLLECTOR_COLLISION_CNT_EN
  logic [NCH-1:0]        s_prev_q;
  logic [NCH-1:0]        other_fall;
  logic [COLL_CNT_W-1:0] coll_q, coll_d;

  always_comb begin
    other_fall         = s_prev_q & ~s;
    other_fall[sel_q]  = 1'b0;
    coll_d             = coll_q;
    if (state_q == ST_LOCKED && |other_fall && coll_q != {COLL_CNT_W{1'b1}}) begin
      coll_d = coll_q + COLL_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_prev_q <= '1;
      coll_q   <= '0;
    end else begin
      s_prev_q <= s;
      coll_q   <= coll_d;
    end
  end

  assign COLL_CNT = coll_q;
`else
  assign COLL_CNT = '0;
`endif

endmodule

// File: tb/tb_rx_collector.sv
// Scoreboard bench for rx_collector: a frame-level model predicts every output change, a monitor checks them.
module tb_rx_collector;

  localparam int NCH   = 22;
  localparam int SYNC  = 2;
  localparam int IDLE  = 1250;
  localparam int SEL_W = 5;

  typedef struct {
    int              cyc;
    logic            out;
    logic            busy;
    logic [SEL_W-1:0] sel;
    logic [7:0]      coll;
  } exp_t;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [NCH-1:0]   in_w = '1;
  logic             OUT, LED, BUSY;
  logic [SEL_W-1:0] SEL;
  logic [7:0]       COLL_CNT;

  int n_chk  = 0;
  int n_pass = 0;

  rx_collector #(
    .NCH(NCH), .SYNC_STAGES(SYNC), .IDLE_CYCLES(IDLE), .SEL_W(SEL_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .IN(in_w), .OUT(OUT), .LED(LED),
    .BUSY(BUSY), .SEL(SEL), .COLL_CNT(COLL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  // The model sees each line two edges late (synchronizer), forwards the first
  // line to go low, and releases after IDLE consecutive high samples of it.
  exp_t           sbq[$];
  exp_t           last_exp;
  logic [NCH-1:0] d1, d2, prev_view;
  bit             m_lock;
  int             m_sel, m_run, m_coll, e_cyc;
  logic           m_out;

  task automatic model_init();
    d1 = '1; d2 = '1; prev_view = '1;
    m_lock = 0; m_sel = 0; m_run = 0; m_coll = 0; m_out = 1'b1; e_cyc = 0;
    last_exp = '{cyc: -1, out: 1'b1, busy: 1'b0, sel: '0, coll: '0};
  endtask

  task automatic model_edge(input logic [NCH-1:0] v);
    logic [NCH-1:0] view;
    int   low;
    bit   fall;
    exp_t ex;
    view = d2;
    d2   = d1;
    d1   = v;
    fall = 0;
    for (int j = 0; j < NCH; j++)
      if (j != m_sel && prev_view[j] && !view[j]) fall = 1;
`ifdef RX_COLLECTOR_COLLISION_CNT_EN
    if (m_lock && fall && m_coll < 255) m_coll++;
`endif
    if (!m_lock) begin
      low = -1;
      for (int i = 0; i < NCH; i++)
        if (low < 0 && !view[i]) low = i;
      if (low >= 0) begin
        m_lock = 1; m_sel = low; m_out = 1'b0; m_run = 0;
      end else begin
        m_out = 1'b1;
      end
    end else begin
      m_out = view[m_sel];
      if (!view[m_sel]) m_run = 0;
      else begin
        m_run++;
        if (m_run == IDLE) begin m_lock = 0; m_run = 0; end
      end
    end
    prev_view = view;
    ex = '{cyc: e_cyc, out: m_out, busy: m_lock, sel: SEL_W'(m_sel), coll: 8'(m_coll)};
    if ({ex.out, ex.busy, ex.sel, ex.coll} != {last_exp.out, last_exp.busy, last_exp.sel, last_exp.coll})
      sbq.push_back(ex);
    last_exp = ex;
    e_cyc++;
  endtask

  // ---------------- monitor ----------------
  bit          mon_en = 0;
  int          mcyc = -1;
  int          last_rise = 0;
  logic [14:0] dut_now, dut_last;
  exp_t        mx;

  always @(negedge CLK) begin
    if (mon_en) begin
      mcyc++;
      dut_now = {OUT, BUSY, SEL, COLL_CNT};
      if (dut_now !== dut_last) begin
        n_chk++;
        if (sbq.size() == 0) begin
          $display("FAIL sb_unexpected: cyc %0d out=%b busy=%b sel=%0d coll=%0d, expected no change",
                   mcyc, OUT, BUSY, SEL, COLL_CNT);
        end else begin
          mx = sbq.pop_front();
          if (mx.cyc == mcyc && dut_now === {mx.out, mx.busy, mx.sel, mx.coll} && LED === ~OUT)
            n_pass++;
          else
            $display("FAIL sb_event: got cyc %0d out=%b led=%b busy=%b sel=%0d coll=%0d, expected cyc %0d out=%b busy=%b sel=%0d coll=%0d",
                     mcyc, OUT, LED, BUSY, SEL, COLL_CNT, mx.cyc, mx.out, mx.busy, mx.sel, mx.coll);
        end
        if (dut_last[14] == 1'b0 && OUT === 1'b1) last_rise = mcyc;
        if (dut_last[13] == 1'b1 && BUSY === 1'b0) chk("release_gap", mcyc - last_rise, IDLE - 1);
        dut_last = dut_now;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic [NCH-1:0] v);
    in_w = v;
    @(posedge CLK);
    model_edge(v);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic run_two(input int ca, input logic [7:0] ba, input int bla,
                         input int cb, input logic [7:0] bb, input int blb,
                         input int offb, input bit enb, input int idle,
                         input int probe_t, input int probe_sel);
    int len;
    logic [NCH-1:0] v;
    len = 10 * bla;
    if (enb && offb + 10 * blb > len) len = offb + 10 * blb;
    for (int t = 0; t < len + idle; t++) begin
      v = '1;
      if (t < 10 * bla) v[ca] = fbit(ba, t / bla);
      if (enb && t >= offb && t - offb < 10 * blb) v[cb] = fbit(bb, (t - offb) / blb);
      tick(v);
      if (t == probe_t) begin
        chk("probe_busy", BUSY, 1);
        chk("probe_sel", SEL, probe_sel);
      end
    end
  endtask

  initial begin
    logic [NCH-1:0] v;
    int ca, cb, lock_edge;
    model_init();
    dut_last = {1'b1, 1'b0, 5'd0, 8'd0};

    // Reset hold
    repeat (3) @(negedge CLK);
    chk("rst_out", OUT, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_led", LED, 0);
    chk("rst_sel", SEL, 0);
    chk("rst_coll", COLL_CNT, 0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    mon_en = 1;

    // Quiet lines: nothing may change
    repeat (2000) tick('1);
    chk("idle_out", OUT, 1);
    chk("idle_busy", BUSY, 0);

    // 0x55 on IN[5]
    run_two(5, 8'h55, 104, 0, 8'h00, 104, 0, 0, 1400, 10, 5);
    // IN[3] and IN[9] start together; IN[9] has no further falling edges
    run_two(9, 8'hFF, 104, 3, 8'hA6, 104, 0, 1, 1400, 10, 3);

    // IN[2] frame, IN[7] drops 20 cycles in and stays low past the release
    for (int t = 0; t < 1040 + 1250 + 200 + 1400; t++) begin
      v = '1;
      if (t < 1040) v[2] = fbit(8'h3C, t / 104);
      if (t >= 20 && t < 1040 + 1250 + 200) v[7] = 1'b0;
      tick(v);
      if (t == 600) chk("coll_sel", SEL, 2);
    end

    // Terminal-count boundary on IN[11]: 1249 highs then low, later 1250 highs then low
    for (int t = 0; t < 10; t++) begin v = '1; v[11] = 1'b0; tick(v); end
    repeat (IDLE - 1) tick('1);
    for (int t = 0; t < 10; t++) begin
      v = '1; v[11] = 1'b0; tick(v);
      if (t == 5) begin
        chk("term_busy", BUSY, 1);
        chk("term_sel", SEL, 11);
      end
    end
    repeat (IDLE) tick('1);
    for (int t = 0; t < 10; t++) begin v = '1; v[11] = 1'b0; tick(v); end
    repeat (1400) tick('1);

    // Randomized frames, sometimes with a second overlapping talker
    for (int r = 0; r < 8; r++) begin
      int bla, blb;
      ca  = $urandom_range(0, NCH - 1);
      cb  = (ca + $urandom_range(1, NCH - 1)) % NCH;
      bla = $urandom_range(8, 40);
      blb = $urandom_range(8, 40);
      run_two(ca, 8'($urandom_range(0, 255)), bla, cb, 8'($urandom_range(0, 255)), blb,
              $urandom_range(0, 20 * blb), 1'($urandom_range(0, 1)), $urandom_range(200, 1600), -1, 0);
    end
    repeat (1400) tick('1);
    chk("sb_drain", sbq.size(), 0);
    mon_en = 0;

    // Reset in the middle of a frame on IN[0]
    v = '1; v[0] = 1'b0; in_w = v;
    repeat (50) @(posedge CLK);
    #1;
    chk("mid_out", OUT, 0);
    chk("mid_busy", BUSY, 1);
    chk("mid_sel", SEL, 0);
    @(negedge CLK);
    #1 RST_N = 1'b0;
    #1;
    chk("arst_out", OUT, 1);
    chk("arst_busy", BUSY, 0);
    chk("arst_led", LED, 0);
    chk("arst_coll", COLL_CNT, 0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    lock_edge = -1;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK);
      #1;
      if (BUSY === 1'b1) begin lock_edge = k; break; end
    end
    chk("relock_edge", lock_edge, SYNC);
    chk("relock_out", OUT, 0);
    chk("relock_sel", SEL, 0);
    chk("relock_led", LED, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
